// File: rtl/ifetch_queue.sv
// ifetch_queue: decoupled instruction-fetch front end.
//
// Runs ahead of decode, fetching one word per cycle from the ICACHE into a
// DEPTH-entry circular queue. Decode pops {pc, instruction} pairs. A redirect
// squashes the queue and any in-flight miss.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   icache_ren      fetch request (REQ or KILL)
//   icache_addr     fetch word address, held stable while icache_stall=1
//   icache_stall    cache busy; rdata valid only when ren=1 and stall=0
//   icache_rdata    instruction word from the cache
//   redirect_valid  control-flow change; discard everything fetched
//   redirect_pc     new fetch word address
//   deq_valid       head entry valid
//   deq_ready       decode accepts the head entry this cycle
//   deq_ir, deq_pc  head instruction and its word address
//   count           occupied entries
//
// Optional feature: define IFQ_BYPASS_EN to forward a cache hit straight to
// decode when the queue is empty (0-cycle hit-to-decode latency).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no request outstanding (queue full, or just out of reset)
// REQ   | request to fetch_pc outstanding; accepted when stall drops
// KILL  | in-flight miss to a stale address; wait it out, then refetch
module ifetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 30,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     icache_ren,
    output logic [ADDR_W-1:0]        icache_addr,
    input  logic                     icache_stall,
    input  logic [DATA_W-1:0]        icache_rdata,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [DATA_W-1:0]        deq_ir,
    output logic [ADDR_W-1:0]        deq_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [ADDR_W-1:0]   pend_pc;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    count_q;
    logic [ADDR_W-1:0]   ent_pc [DEPTH];
    logic [DATA_W-1:0]   ent_ir [DEPTH];

    logic                accept;
    logic                push;
    logic                pop;
    logic [CNT_W-1:0]    count_next;

    assign accept = (state == REQ) && !icache_stall && !redirect_valid;

`ifdef IFQ_BYPASS_EN
    logic bypass;

    // Empty queue and a hit this cycle: present the cache word directly.
    // If decode takes it, it never enters the queue.
    assign bypass    = accept && (count_q == '0);
    assign deq_valid = ((count_q != '0) && !redirect_valid) || bypass;
    assign deq_ir    = bypass ? icache_rdata : ent_ir[rd_ptr];
    assign deq_pc    = bypass ? fetch_pc     : ent_pc[rd_ptr];
    assign push      = accept && !(bypass && deq_ready);
    assign pop       = (count_q != '0) && !redirect_valid && deq_ready;
`else
    assign deq_valid = (count_q != '0) && !redirect_valid;
    assign deq_ir    = ent_ir[rd_ptr];
    assign deq_pc    = ent_pc[rd_ptr];
    assign push      = accept;
    assign pop       = deq_valid && deq_ready;
`endif

    assign count_next  = count_q + CNT_W'(push) - CNT_W'(pop);

    assign icache_ren  = (state == REQ) || (state == KILL);
    assign icache_addr = fetch_pc;
    assign count       = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            pend_pc  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc[i] <= '0;
                ent_ir[i] <= '0;
            end
        end else begin
            // Queue datapath; a redirect flushes regardless of state.
            if (redirect_valid) begin
                count_q <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
            end else begin
                if (push) begin
                    ent_pc[wr_ptr] <= fetch_pc;
                    ent_ir[wr_ptr] <= icache_rdata;
                    wr_ptr         <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count_q <= count_next;
            end

            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_pc;
                    end else if (count_next < DEPTH_C) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (redirect_valid) begin
                        if (icache_stall) begin
                            // The miss cannot be cancelled; keep addr stable
                            // and remember where to go once it completes.
                            pend_pc <= redirect_pc;
                            state   <= KILL;
                        end else begin
                            fetch_pc <= redirect_pc;
                        end
                    end else if (!icache_stall) begin
                        fetch_pc <= fetch_pc + ADDR_W'(1);
                        if (count_next == DEPTH_C) begin
                            state <= IDLE;
                        end
                    end
                end
                KILL: begin
                    if (redirect_valid) begin
                        pend_pc <= redirect_pc;
                    end
                    if (!icache_stall) begin
                        fetch_pc <= redirect_valid ? redirect_pc : pend_pc;
                        state    <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icache_ren;
    logic [29:0] icache_addr;
    logic        icache_stall;
    logic [31:0] icache_rdata;
    logic        redirect_valid;
    logic [29:0] redirect_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_ir;
    logic [29:0] deq_pc;
    logic [2:0]  count;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    ifetch_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icache_ren     (icache_ren),
        .icache_addr    (icache_addr),
        .icache_stall   (icache_stall),
        .icache_rdata   (icache_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_ir         (deq_ir),
        .deq_pc         (deq_pc),
        .count          (count)
    );

    always #5 clk = ~clk;

    // Cache model: always returns a word tagged with its own address.
    function automatic logic [31:0] ir_of(input logic [29:0] a);
        return {2'b11, a};
    endfunction

    assign icache_rdata = ir_of(icache_addr);

    task automatic check_eq(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        icache_stall   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        icache_stall   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        deq_ready      = 1'b1;
        #3;
        check_eq("rst_ren",   icache_ren,  0);
        check_eq("rst_addr",  icache_addr, 0);
        check_eq("rst_dv",    deq_valid,   0);
        check_eq("rst_ir",    deq_ir,      0);
        check_eq("rst_pc",    deq_pc,      0);
        check_eq("rst_count", count,       0);

        // Streaming hits with decode always ready.
        deq_ready = 1'b1;
        do_reset();
        step();
        check_eq("a_ren",   icache_ren,  1);
        check_eq("a_addr0", icache_addr, 0);
        check_eq("a_cnt0",  count,       0);
        check_eq("a_dv0",   deq_valid,   BYP);
        for (int i = 0; i < 6; i++) begin
            logic [29:0] epc;
            epc = BYP ? 30'(i + 1) : 30'(i);
            step();
            check_eq("a_addr",  icache_addr, i + 1);
            check_eq("a_dv",    deq_valid,   1);
            check_eq("a_pc",    deq_pc,      epc);
            check_eq("a_ir",    deq_ir,      ir_of(epc));
            check_eq("a_count", count,       BYP ? 0 : 1);
        end

        // Fill with decode stalled, then drain.
        deq_ready = 1'b0;
        do_reset();
        step();
        check_eq("b_ren1", icache_ren, 1);
        step(); step(); step();
        check_eq("b_cnt3", count,      3);
        check_eq("b_ren4", icache_ren, 1);
        step();
        check_eq("b_cnt4",  count,       4);
        check_eq("b_ren0",  icache_ren,  0);
        check_eq("b_addr4", icache_addr, 4);
        check_eq("b_head0", deq_pc,      0);
        step();
        check_eq("b_hold_ren", icache_ren, 0);
        check_eq("b_hold_cnt", count,      4);
        deq_ready = 1'b1;
        #1;
        check_eq("b_dv",  deq_valid, 1);
        check_eq("b_pc0", deq_pc,    0);
        step();
        check_eq("b_cnt_pop", count,       3);
        check_eq("b_ren_re",  icache_ren,  1);
        check_eq("b_addr_re", icache_addr, 4);
        check_eq("b_pc1",     deq_pc,      1);
        step();
        check_eq("b_pc2",  deq_pc, 2);
        check_eq("b_cnt3b", count, 3);
        step();
        check_eq("b_pc3", deq_pc, 3);
        step();
        check_eq("b_pc4", deq_pc, 4);
        check_eq("b_ir4", deq_ir, ir_of(30'd4));

        // Redirect with no stall flushes a partly full queue.
        deq_ready = 1'b0;
        do_reset();
        repeat (4) step();
        redirect_valid = 1'b1;
        redirect_pc    = 30'h100;
        #1;
        check_eq("c_dv_redir", deq_valid, 0);
        check_eq("c_cnt3",     count,     3);
        step();
        redirect_valid = 1'b0;
        #1;
        check_eq("c_cnt0", count,       0);
        check_eq("c_addr", icache_addr, 30'h100);
        check_eq("c_ren",  icache_ren,  1);
        check_eq("c_dv0",  deq_valid,   BYP);
        step();
        check_eq("c_cnt1", count,  1);
        check_eq("c_pc",   deq_pc, 30'h100);
        check_eq("c_ir",   deq_ir, ir_of(30'h100));

        // Miss on addr 5, redirect during the miss.
        deq_ready = 1'b1;
        do_reset();
        repeat (6) step();
        icache_stall = 1'b1;
        #1;
        check_eq("d_addr5", icache_addr, 5);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 30'h40;
        deq_ready      = 1'b0;
        #1;
        check_eq("d_cnt0", count,     0);
        check_eq("d_dv0",  deq_valid, 0);
        step();
        redirect_valid = 1'b0;
        #1;
        check_eq("d_kill_addr", icache_addr, 5);
        check_eq("d_kill_ren",  icache_ren,  1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("d_hold_addr", icache_addr, 5);
            check_eq("d_hold_dv",   deq_valid,   0);
        end
        icache_stall = 1'b0;
        step();
        check_eq("d_new_addr", icache_addr, 30'h40);
        check_eq("d_new_cnt",  count,       0);
        check_eq("d_new_dv",   deq_valid,   BYP);
        step();
        check_eq("d_first_cnt", count,  1);
        check_eq("d_first_pc",  deq_pc, 30'h40);
        check_eq("d_first_ir",  deq_ir, ir_of(30'h40));

        // Asynchronous reset in the middle of a miss.
        icache_stall = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check_eq("r_ren",  icache_ren,  0);
        check_eq("r_cnt",  count,       0);
        check_eq("r_addr", icache_addr, 0);

        // Address wrap, then two redirects while a miss is in flight.
        deq_ready = 1'b0;
        do_reset();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 30'h3FFF_FFFF;
        step();
        redirect_valid = 1'b0;
        #1;
        check_eq("e_addr_top", icache_addr, 30'h3FFF_FFFF);
        check_eq("e_cnt0",     count,       0);
        step();
        check_eq("e_addr_wrap", icache_addr, 0);
        check_eq("e_cnt1",      count,       1);
        check_eq("e_pc_top",    deq_pc,      30'h3FFF_FFFF);
        check_eq("e_ir_top",    deq_ir,      ir_of(30'h3FFF_FFFF));
        icache_stall = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 30'h10;
        step();
        redirect_pc = 30'h20;
        #1;
        check_eq("e_kill_addr", icache_addr, 0);
        check_eq("e_kill_cnt",  count,       0);
        check_eq("e_kill_ren",  icache_ren,  1);
        step();
        redirect_valid = 1'b0;
        icache_stall   = 1'b0;
        #1;
        check_eq("e_kill_hold", icache_addr, 0);
        step();
        check_eq("e_pend_addr", icache_addr, 30'h20);
        step();
        check_eq("e_pend_cnt", count,  1);
        check_eq("e_pend_pc",  deq_pc, 30'h20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
